keypad_scanner: RTL



---
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row-multiplexed sampling, whole-matrix debounce, and
// valid/ready key events. Define KEYSCAN_RELEASE_EVT_EN to also emit release events.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cols,
  output logic [3:0]  rows,
  output logic [15:0] pressed,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [3:0]  key_code,
  output logic        key_release
);

  localparam int DW = $clog2(SETTLE_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t        state, state_next;
  logic [1:0]    row;
  logic [DW-1:0] dwell;
  logic [15:0]   snapshot, prev_snapshot;
  logic [SW-1:0] stable, stable_next;
  logic          scan_done, commit, rel_q;
  logic [15:0]   pend_press, pend_rel;
  logic [15:0]   press_left, rel_left, press_next, rel_next;

  function automatic logic [3:0] lowest(input logic [15:0] v);
    lowest = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) lowest = 4'(i);
  endfunction

  assign rows = rst ? 4'b1111 : ~(4'b0001 << row);

  // scan_done pulses on the cycle after row 3 was sampled, when snapshot holds a full scan
  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= 2'd0;
      dwell     <= '0;
      snapshot  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (dwell == DWELL_LAST) begin
        dwell                       <= '0;
        row                         <= row + 2'd1;
        snapshot[{row, 2'b00} +: 4] <= ~cols;
        scan_done                   <= (row == 2'd3);
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  always_comb begin
    stable_next = stable;
    if (snapshot == prev_snapshot) begin
      if (stable != STABLE_MAX) stable_next = stable + SW'(1);
    end else begin
      stable_next = SW'(1);
    end
    commit = scan_done && (stable_next == STABLE_MAX) && (snapshot != pressed);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_snapshot <= '0;
      stable        <= STABLE_MAX;
      pressed       <= '0;
    end else if (scan_done) begin
      stable        <= stable_next;
      prev_snapshot <= snapshot;
      if (commit) pressed <= snapshot;
    end
  end

  // The accepted event is cleared first so a same-cycle commit sees the remaining set
  always_comb begin
    press_left = pend_press;
    rel_left   = pend_rel;
    if (state == OFFER && key_ready) begin
      if (rel_q) rel_left[key_code]   = 1'b0;
      else       press_left[key_code] = 1'b0;
    end
    press_next = press_left;
    rel_next   = rel_left;
    if (commit) begin
      press_next = (press_left & snapshot) | (snapshot & ~pressed);
`ifdef KEYSCAN_RELEASE_EVT_EN
      rel_next   = (rel_left & ~snapshot) | (pressed & ~snapshot);
`else
      rel_next   = '0;
`endif
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if ((|pend_press) || (|pend_rel)) state_next = OFFER;
      OFFER:   if (key_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend_press <= '0;
      pend_rel   <= '0;
      key_code   <= 4'd0;
      rel_q      <= 1'b0;
    end else begin
      state      <= state_next;
      pend_press <= press_next;
      pend_rel   <= rel_next;
      if (state == IDLE && state_next == OFFER) begin
        if (|pend_press) begin
          key_code <= lowest(pend_press);
          rel_q    <= 1'b0;
        end else begin
          key_code <= lowest(pend_rel);
          rel_q    <= 1'b1;
        end
      end
    end
  end

  assign key_valid = (state == OFFER);

`ifdef KEYSCAN_RELEASE_EVT_EN
  assign key_release = rel_q;
`else
  assign key_release = 1'b0;
`endif

endmodule
